// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one synchronous RAM port between the CPU and the DMA
// master. Round-robin with a bounded tenure under contention; grants and read
// valids are registered, the RAM address/data/we mux is combinational.
module mem_bus_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4   // 1..15
) (
  input  logic              clk,
  input  logic              reset,      // async, active low
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner_out
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  localparam logic [4:0] MAX_B = 5'(MAX_BURST);

  owner_t     owner, owner_nxt;
  logic       last_dma, last_dma_nxt;   // 1 = DMA was served last
  logic [3:0] count, count_nxt;
  logic [4:0] count_inc;
  logic       burst_end;

  assign count_inc = {1'b0, count} + 5'd1;
  // >= also covers the saturated case where the other master arrives late
  assign burst_end = (count_inc >= MAX_B);

  // Next owner / tenure bookkeeping
  always_comb begin
    owner_nxt    = owner;
    last_dma_nxt = last_dma;
    count_nxt    = count;
    case (owner)
      OWN_NONE: begin
        count_nxt = 4'd0;
        if (cpu_req && (!dma_req || last_dma)) owner_nxt = OWN_CPU;
        else if (dma_req)                      owner_nxt = OWN_DMA;
      end
      OWN_CPU: begin
        if (!cpu_req) begin
          owner_nxt    = OWN_NONE;
          last_dma_nxt = 1'b0;
          count_nxt    = 4'd0;
        end else if (dma_req && burst_end) begin
          owner_nxt    = OWN_DMA;
          last_dma_nxt = 1'b0;
          count_nxt    = 4'd0;
        end else if (count_inc <= MAX_B) begin
          count_nxt = count_inc[3:0];
        end
      end
      OWN_DMA: begin
        if (!dma_req) begin
          owner_nxt    = OWN_NONE;
          last_dma_nxt = 1'b1;
          count_nxt    = 4'd0;
        end else if (cpu_req && burst_end) begin
          owner_nxt    = OWN_CPU;
          last_dma_nxt = 1'b1;
          count_nxt    = 4'd0;
        end else if (count_inc <= MAX_B) begin
          count_nxt = count_inc[3:0];
        end
      end
      default: owner_nxt = OWN_NONE;
    endcase
  end

  // Owner state, decoded grants and one-cycle read valids
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner      <= OWN_NONE;
      last_dma   <= 1'b1;
      count      <= 4'd0;
      cpu_gnt    <= 1'b0;
      dma_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
    end else begin
      owner      <= owner_nxt;
      last_dma   <= last_dma_nxt;
      count      <= count_nxt;
      cpu_gnt    <= (owner_nxt == OWN_CPU);
      dma_gnt    <= (owner_nxt == OWN_DMA);
      cpu_rvalid <= cpu_req & cpu_gnt & ~cpu_we;
      dma_rvalid <= dma_req & dma_gnt & ~dma_we;
    end
  end

  // RAM port mux from the current owner; quiet bus when nobody owns it
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (owner)
      OWN_CPU: begin
        mem_en    = cpu_req;
        mem_we    = cpu_req & cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      OWN_DMA: begin
        mem_en    = dma_req;
        mem_we    = dma_req & dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
      end
      default: ;
    endcase
  end

  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;
  assign owner_out = owner;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed vectors against a behavioural sync RAM.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr, mem_addr;
  logic [7:0]  cpu_wdata, dma_wdata, mem_wdata, mem_rdata, cpu_rdata, dma_rdata;
  logic        cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_en, mem_we;
  logic [1:0]  owner_out;

  logic [7:0] ram [0:65535];
  int checks = 0, failures = 0;

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner_out(owner_out)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears one cycle after the strobe
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rd_exp [0:3];

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0010] = 8'hA9;
    rd_exp[0] = 8'h3C; rd_exp[1] = 8'hC3; rd_exp[2] = 8'h5A; rd_exp[3] = 8'hA5;
    for (int i = 0; i < 4; i++) ram[16'h0300 + i] = rd_exp[i];
    mem_rdata = 8'h00;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;

    // Reset, idle
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    tick();
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_dma_gnt", dma_gnt, 0);
    chk("rst_owner", owner_out, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_rvalid", {cpu_rvalid, dma_rvalid}, 0);

    // CPU single read of 0x0010
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    tick();
    chk("rd1_gnt", cpu_gnt, 1);
    chk("rd1_mem_en", mem_en, 1);
    chk("rd1_mem_addr", mem_addr, 16'h0010);
    chk("rd1_rvalid_early", cpu_rvalid, 0);
    tick();
    chk("rd1_rvalid", cpu_rvalid, 1);
    chk("rd1_rdata", cpu_rdata, 8'hA9);
    cpu_req = 0;
    tick();
    chk("rd1_idle_owner", owner_out, 0);
    chk("rd1_idle_gnt", cpu_gnt, 0);
    chk("rd1_rvalid_drop", cpu_rvalid, 0);

    // Simultaneous request straight out of reset: CPU first, 4/4 alternation
    reset = 1'b0; tick(); reset = 1'b1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0100; cpu_wdata = 8'h11;
    dma_req = 1; dma_we = 1; dma_addr = 16'h0180; dma_wdata = 8'h22;
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk($sformatf("tie_owner_c%0d", c), owner_out, (c >= 5 && c <= 8) ? 2 : 1);
    end
    cpu_req = 0; dma_req = 0;
    tick();
    chk("tie_release", owner_out, 0);

    // Uncontended DMA burst of 20 writes
    dma_req = 1; dma_we = 1; dma_addr = 16'h0200; dma_wdata = 8'h00;
    tick();
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("burst_gnt_%0d", k), {cpu_gnt, dma_gnt}, 2'b01);
      dma_addr = 16'h0200 + 16'(k); dma_wdata = 8'(k);
      tick();
    end
    chk("burst_still_dma", dma_gnt, 1);
    // CPU arrives on a saturated tenure: exactly one more DMA transfer
    dma_addr = 16'h0214; dma_wdata = 8'h14;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0300;
    tick();
    chk("handoff_cpu_gnt", cpu_gnt, 1);
    chk("handoff_dma_gnt", dma_gnt, 0);
    for (int k = 0; k <= 20; k++)
      chk($sformatf("burst_ram_%0d", k), ram[16'h0200 + k], k);

    // Back-to-back CPU reads with DMA waiting
    dma_addr = 16'h0400; dma_wdata = 8'h55;
    for (int j = 0; j < 4; j++) begin
      cpu_addr = 16'h0300 + 16'(j);
      tick();
      chk($sformatf("pipe_rvalid_%0d", j), cpu_rvalid, 1);
      chk($sformatf("pipe_rdata_%0d", j), cpu_rdata, rd_exp[j]);
    end
    chk("pipe_dma_gnt", dma_gnt, 1);
    chk("pipe_cpu_gnt", cpu_gnt, 0);
    chk("pipe_dma_rvalid", dma_rvalid, 0);
    cpu_req = 0;
    tick();
    chk("pipe_rvalid_end", cpu_rvalid, 0);
    chk("pipe_dma_wr", ram[16'h0400], 8'h55);
    dma_req = 0;
    tick();
    chk("pipe_idle", owner_out, 0);

    // Reset while a CPU read is on the bus
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    tick();
    chk("mid_gnt", cpu_gnt, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_async_gnt", cpu_gnt, 0);
    chk("mid_async_owner", owner_out, 0);
    tick();
    chk("mid_rvalid_in_rst", cpu_rvalid, 0);
    cpu_req = 0; reset = 1'b1;
    tick();
    chk("mid_rvalid_after", cpu_rvalid, 0);
    chk("mid_owner_after", owner_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
